ps2_scancode_receiver: RTL
==========================

// Module: ps2_scancode_receiver
// PURPOSE
//  Receives device-to-host PS/2 keyboard frames on raw ps2_clk/ps2_data pins.
//  Filters, deserialises and parity-checks each frame; strips F0 (break) and E0 (extended) prefixes.
//  Emits one scancode + 1-cycle scancode_valid per key make, directly feeding the direction decoder.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal samples needed before filtered ps2_clk changes
//  TIMEOUT_CYCLES  100000  clk cycles without a ps2_clk falling edge that abort a partial frame
// PORTS
//  clk             in   1  system clock; the only clock
//  rst             in   1  synchronous, active-high reset
//  ps2_clk         in   1  raw PS/2 clock pin (asynchronous, idle high)
//  ps2_data        in   1  raw PS/2 data pin (asynchronous, idle high)
//  scancode        out  8  last accepted make code; holds between pulses
//  scancode_valid  out  1  1-cycle pulse: scancode is new
//  extended        out  1  make code was preceded by E0; valid with scancode_valid
//  frame_error     out  1  1-cycle pulse: parity, start/stop or timeout failure
// BEHAVIOUR
//  Reset: scancode=8'h00, scancode_valid=0, extended=0, frame_error=0, FSM=IDLE,
//   break/ext pending flags=0, sync flops and filtered clock=1, counters=0. Reset mid-frame discards the frame.
//  Input path: 2-flop synchroniser on each pin. Filtered clock toggles only after FILTER_LEN
//   consecutive synchronised samples differ from its current value. edge = filtered clock 1->0, one cycle.
//  Data bit is the synchronised ps2_data sampled in the edge cycle.
//  FSM (advances only on edge, except timeout):
//   IDLE: data=0 -> DATA, bitcnt=0; data=1 -> stay (spurious edge, no error).
//   DATA: shift LSB-first into byte reg; after 8th bit -> PARITY.
//   PARITY: store bit; -> STOP.
//   STOP: ok = (data==1) && (XOR of 8 data bits + parity == 1, odd parity). -> IDLE always.
//  Byte handling when STOP is ok:
//   byte==F0: break_pending=1, no output.  byte==E0: ext_pending=1, no output.
//   other, break_pending=1: discard (key release); clear both flags.
//   other, break_pending=0: scancode<=byte, extended<=ext_pending, scancode_valid=1; clear both flags.
//  Latency: scancode_valid/frame_error assert exactly one clk after the stop-bit edge cycle.
//  Failure (STOP not ok): frame_error pulse, byte dropped, both pending flags cleared, -> IDLE.
//  Timeout: outside IDLE, idle counter resets on each edge, increments otherwise; on reaching
//   TIMEOUT_CYCLES-1: frame_error pulse, flags cleared, -> IDLE. Counter held at 0 in IDLE.
//  Timeout and edge in same cycle: the edge wins (counter resets, bit accepted).
//  scancode_valid and frame_error are never asserted in the same cycle.
//  Back-to-back frames: no dead time required; next start bit accepted in IDLE on the following edge.
// TESTING  (sim params FILTER_LEN=4, TIMEOUT_CYCLES=1000; PS/2 bit period 400 clk)
//  1 frame 0x75, parity 0, stop 1 -> one scancode_valid pulse, scancode=0x75, extended=0.
//  2 frames F0 then 75 -> no scancode_valid, no frame_error; scancode stays 0x75 from test 1.
//  3 frames E0 then 6B -> one pulse, scancode=0x6B, extended=1; then 74 alone -> 0x74, extended=0.
//  4 frame 0x73 with parity 1 -> frame_error pulse, no valid; next 0x74 (parity 1) -> valid, 0x74.
//  5 3-cycle low glitch on ps2_clk while idle, then frame 0x6B -> no bit sampled by glitch; valid 0x6B.
//  6 start + 4 bits then 1500 clk idle -> frame_error pulse ~1000 clk after last edge; then 0x75 -> valid.
//    Also assert rst mid-frame: outputs at reset values next cycle, following full 0x74 frame accepted.

Source files
------------

// File: rtl/ps2_scancode_receiver_if.sv
// ps2_scancode_receiver_if
//  Bundles the raw PS/2 pins and the decoded scancode outputs of the
//  receiver so that one port carries the whole keyboard link.
//  Signals:
//   ps2_clk, ps2_data   raw PS/2 pins (asynchronous, idle high)
//   scancode[7:0]       last accepted make code, holds between pulses
//   scancode_valid      1-cycle pulse, scancode is new
//   extended            make code was preceded by E0, valid with scancode_valid
//   frame_error         1-cycle pulse, parity / start-stop / timeout failure
//  Modports:
//   master  the receiver: samples the pins, drives the decoded outputs
//   slave   the keyboard side / consumer: drives the pins, reads the outputs
interface ps2_scancode_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       extended;
  logic       frame_error;

  modport master (
    input  ps2_clk, ps2_data,
    output scancode, scancode_valid, extended, frame_error
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scancode, scancode_valid, extended, frame_error
  );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver
//  Receives device-to-host PS/2 keyboard frames on the raw pins, filters the
//  PS/2 clock, deserialises start/8 data/odd parity/stop, and strips the F0
//  (break) and E0 (extended) prefixes. One scancode_valid pulse per key make.
//  Parameters:
//   FILTER_LEN      consecutive equal samples before the filtered clock changes
//   TIMEOUT_CYCLES  clk cycles without a PS/2 clock fall that abort a frame
//  Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   ps2_scancode_receiver_if.master (pins in, decoded scancode out)
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  ps2_scancode_receiver_if.master        bus
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  logic [7:0]    shift_reg;
  logic [2:0]    bitcnt;
  logic          parity_bit;
  logic [TW-1:0] idle_cnt;
  logic          break_pending, ext_pending;

  logic          timeout, frame_ok, frame_fail;

  logic [7:0]    scancode_r;
  logic          scancode_valid_r, extended_r, frame_error_r;

  // Input synchronisers and clock glitch filter
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_s1     <= bus.ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= bus.ps2_data;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      // Any sample agreeing with the filtered level restarts the run count.
      if (clk_s2 != clk_filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_s2;
          flt_cnt  <= '0;
        end else begin
          flt_cnt  <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a clock edge takes priority over a coincident timeout
  always_comb begin
    state_next = state;
    if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_next = DATA;
        DATA:    if (bitcnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
    end
  end

  // Output decode: frame verdict at the stop bit, and the timeout strobe
  always_comb begin
    timeout    = 1'b0;
    frame_ok   = 1'b0;
    frame_fail = 1'b0;
    if (state != IDLE && !fall && idle_cnt == TW'(TIMEOUT_CYCLES - 1))
      timeout = 1'b1;
    if (state == STOP && fall) begin
      // Odd parity: data bits plus parity bit must hold an odd number of ones.
      if (dat_s2 && (^{shift_reg, parity_bit})) frame_ok   = 1'b1;
      else                                      frame_fail = 1'b1;
    end
  end

  // Datapath, prefix handling and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg        <= '0;
      bitcnt           <= '0;
      parity_bit       <= 1'b0;
      idle_cnt         <= '0;
      break_pending    <= 1'b0;
      ext_pending      <= 1'b0;
      scancode_r       <= '0;
      scancode_valid_r <= 1'b0;
      extended_r       <= 1'b0;
      frame_error_r    <= 1'b0;
    end else begin
      scancode_valid_r <= 1'b0;
      frame_error_r    <= 1'b0;

      if (state == IDLE || fall || timeout) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + TW'(1);

      if (fall) begin
        case (state)
          IDLE:    bitcnt <= '0;
          DATA: begin
            shift_reg <= {dat_s2, shift_reg[7:1]};
            bitcnt    <= bitcnt + 3'd1;
          end
          PARITY:  parity_bit <= dat_s2;
          default: ;
        endcase
      end

      if (frame_ok) begin
        if (shift_reg == 8'hF0) begin
          break_pending <= 1'b1;
        end else if (shift_reg == 8'hE0) begin
          ext_pending <= 1'b1;
        end else begin
          if (!break_pending) begin
            scancode_r       <= shift_reg;
            extended_r       <= ext_pending;
            scancode_valid_r <= 1'b1;
          end
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
        end
      end else if (frame_fail || timeout) begin
        frame_error_r <= 1'b1;
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end
    end
  end

  assign bus.scancode       = scancode_r;
  assign bus.scancode_valid = scancode_valid_r;
  assign bus.extended       = extended_r;
  assign bus.frame_error    = frame_error_r;

endmodule
